// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO behind uart_receiver: captures data_ready strobes,
// presents bytes show-ahead over valid/ready, and flags dropped bytes.
module uart_rx_fifo #(
    parameter int DEPTH_BITS = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [7:0]            rx_data,
    input  logic                  rx_data_ready,
    output logic [7:0]            read_data,
    output logic                  read_valid,
    input  logic                  read_ready,
    output logic [DEPTH_BITS:0]   count,
    output logic                  overflow,
    input  logic                  clear_overflow
);

    localparam int DEPTH = 1 << DEPTH_BITS;

    logic [7:0]          mem [DEPTH];
    logic [DEPTH_BITS:0] wr_ptr;
    logic [DEPTH_BITS:0] rd_ptr;

    logic empty;
    logic full;
    logic pop;
    logic push;
    logic drop;

    // The extra pointer MSB separates a wrapped-full FIFO from an empty one.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[DEPTH_BITS-1:0] == rd_ptr[DEPTH_BITS-1:0]) &&
                   (wr_ptr[DEPTH_BITS] != rd_ptr[DEPTH_BITS]);

    assign pop  = !empty && read_ready;
    assign push = rx_data_ready && (!full || pop);
    assign drop = rx_data_ready && full && !pop;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage carries no reset; the pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[DEPTH_BITS-1:0]] <= rx_data;
    end

    // A drop in the same cycle as a clear request keeps the flag set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)            overflow <= 1'b0;
        else if (drop)           overflow <= 1'b1;
        else if (clear_overflow) overflow <= 1'b0;
    end

    assign read_valid = !empty;
    assign read_data  = empty ? 8'h00 : mem[rd_ptr[DEPTH_BITS-1:0]];
    assign count      = wr_ptr - rd_ptr;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed plus randomized bench for uart_rx_fifo against a queue-based model.
module tb_uart_rx_fifo;

    localparam int DB  = 2;
    localparam int CAP = 1 << DB;

    logic          clk;
    logic          reset_n;
    logic [7:0]    rx_data;
    logic          rx_data_ready;
    logic [7:0]    read_data;
    logic          read_valid;
    logic          read_ready;
    logic [DB:0]   count;
    logic          overflow;
    logic          clear_overflow;

    int tests = 0;
    int fails = 0;

    logic [7:0] q[$];
    logic       m_ovf;

    uart_rx_fifo #(.DEPTH_BITS(DB)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .rx_data        (rx_data),
        .rx_data_ready  (rx_data_ready),
        .read_data      (read_data),
        .read_valid     (read_valid),
        .read_ready     (read_ready),
        .count          (count),
        .overflow       (overflow),
        .clear_overflow (clear_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".valid"},    32'(read_valid), 32'(q.size() != 0));
        chk({tag, ".count"},    32'(count),      32'(q.size()));
        chk({tag, ".data"},     32'(read_data),  (q.size() != 0) ? 32'(q[0]) : 32'h0);
        chk({tag, ".overflow"}, 32'(overflow),   32'(m_ovf));
    endtask

    // One clock: drive inputs, advance past the edge, update model, check.
    task automatic step(input string tag, input logic [7:0] d, input logic s,
                        input logic r, input logic c);
        logic do_pop, do_push, do_drop;
        rx_data        = d;
        rx_data_ready  = s;
        read_ready     = r;
        clear_overflow = c;
        do_pop  = (q.size() != 0) && r;
        do_push = s && ((q.size() < CAP) || do_pop);
        do_drop = s && (q.size() == CAP) && !do_pop;
        @(posedge clk);
        #1;
        if (do_pop)  void'(q.pop_front());
        if (do_push) q.push_back(d);
        if (do_drop)     m_ovf = 1'b1;
        else if (c)      m_ovf = 1'b0;
        rx_data_ready  = 1'b0;
        clear_overflow = 1'b0;
        read_ready     = 1'b0;
        check_model(tag);
    endtask

    initial begin
        logic [7:0] fill [4];
        fill[0] = 8'h11; fill[1] = 8'h22; fill[2] = 8'h33; fill[3] = 8'h44;
        rx_data = 8'h00; rx_data_ready = 1'b0; read_ready = 1'b0; clear_overflow = 1'b0;
        m_ovf = 1'b0;

        // Reset and idle
        reset_n = 1'b0;
        #3;
        check_model("reset");
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        step("idle", 8'h00, 1'b0, 1'b0, 1'b0);
        step("idle_rr", 8'h00, 1'b0, 1'b1, 1'b0);

        // Fill, overflow, drain
        for (int i = 0; i < 4; i++) begin
            step("fill", fill[i], 1'b1, 1'b0, 1'b0);
            chk("fill.count_abs", 32'(count), 32'(i + 1));
        end
        step("fill5", 8'h55, 1'b1, 1'b0, 1'b0);
        chk("fill5.count_abs", 32'(count), 32'd4);
        chk("fill5.ovf_abs", 32'(overflow), 32'd1);
        for (int i = 0; i < 4; i++) begin
            chk("drain.head_abs", 32'(read_data), 32'(fill[i]));
            step("drain", 8'h00, 1'b0, 1'b1, 1'b0);
        end
        chk("drain.empty_abs", 32'(read_valid), 32'd0);

        // Full push+pop
        step("clr", 8'h00, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step("refill", fill[i], 1'b1, 1'b0, 1'b0);
        step("fullpp", 8'h66, 1'b1, 1'b1, 1'b0);
        chk("fullpp.count_abs", 32'(count), 32'd4);
        chk("fullpp.ovf_abs", 32'(overflow), 32'd0);
        chk("fullpp.head_abs", 32'(read_data), 32'h22);
        repeat (4) step("fullpp_drain", 8'h00, 1'b0, 1'b1, 1'b0);
        chk("fullpp.empty_abs", 32'(read_valid), 32'd0);

        // Empty push with read_ready high
        chk("emptypush.pre_valid", 32'(read_valid), 32'd0);
        step("emptypush", 8'hA5, 1'b1, 1'b1, 1'b0);
        chk("emptypush.valid_abs", 32'(read_valid), 32'd1);
        chk("emptypush.data_abs", 32'(read_data), 32'hA5);
        step("emptypush_pop", 8'h00, 1'b0, 1'b1, 1'b0);
        chk("emptypush.after_abs", 32'(read_valid), 32'd0);

        // Overflow clear race
        for (int i = 0; i < 4; i++) step("race_fill", fill[i], 1'b1, 1'b0, 1'b0);
        step("race", 8'h77, 1'b1, 1'b0, 1'b1);
        chk("race.ovf_abs", 32'(overflow), 32'd1);
        step("race_clr", 8'h00, 1'b0, 1'b0, 1'b1);
        chk("race_clr.ovf_abs", 32'(overflow), 32'd0);

        // Asynchronous reset mid-operation
        #3 reset_n = 1'b0;
        #1;
        q.delete();
        m_ovf = 1'b0;
        check_model("midreset");
        #2 reset_n = 1'b1;
        step("post_reset", 8'h00, 1'b0, 1'b0, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic [7:0] d;
            logic s, r, c;
            d = 8'($urandom);
            s = ($urandom_range(0, 99) < 55);
            r = ($urandom_range(0, 99) < ((i < 300) ? 35 : 70));
            c = ($urandom_range(0, 99) < 8);
            step("rand", d, s, r, c);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
